serial_paralelo: RTL and testbench

SERIAL_PARALELO -- requirements
Module: serial_paralelo

---
 rtl/serial_paralelo_pkg.sv | 29 ++
 rtl/serial_paralelo_deserializador_byte.sv | 50 +++++
 rtl/serial_paralelo.sv | 150 +++++++++++++++
 tb/tb_serial_paralelo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_paralelo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_pkg
// Description : Shared constants for the serial-to-parallel front end and the
//               recirculation stage: alignment symbol, sync threshold, FSM
//               state encoding and lane count.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_paralelo_pkg;

  // Alignment / idle symbol and number of consecutive COMs needed for lock
  localparam logic [7:0] c_COM       = 8'hBC;
  localparam int         c_BC_TARGET = 4;

  // Number of output lanes fed by the demux
  localparam int         c_NUM_LANES = 4;

  // FSM state encoding, shared with downstream stages and benches
  localparam logic [1:0] c_ST_SEARCH = 2'd0;
  localparam logic [1:0] c_ST_SYNC   = 2'd1;
  localparam logic [1:0] c_ST_ACTIVE = 2'd2;

  // Advance a lane pointer, wrapping after the last lane
  function automatic logic [1:0] next_lane(input logic [1:0] lane);
    return lane + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_paralelo_deserializador_byte.sv
`default_nettype none
// ============================================================================
// Module      : deserializador_byte
// Description : Serial-in shift register with a free-running 3-bit bit
//               counter. The counter is reloaded to 0 on the edge that
//               defines a byte boundary, so byte_done flags the eighth edge
//               after it, and every eighth edge thereafter.
// Ports       : clk       - rising-edge clock
//               reset     - asynchronous active-low reset
//               data_in   - serial input bit, MSB first
//               reload    - byte boundary lands on this edge
//               cand      - candidate byte {sr[6:0], data_in}
//               bit_cnt   - bit position within the current byte
//               byte_done - the current edge completes a byte (cand is it)
// Revision    : 1.0 - initial release
// ============================================================================
module deserializador_byte (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic       reload,
  output logic [7:0] cand,
  output logic [2:0] bit_cnt,
  output logic       byte_done
);

  logic [7:0] r_sr;
  logic [2:0] r_bit_cnt;

  assign cand      = {r_sr[6:0], data_in};
  assign bit_cnt   = r_bit_cnt;
  assign byte_done = (r_bit_cnt == 3'd7);

  // The shift register runs in every state; only the counter is steered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr      <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else begin
      r_sr <= cand;
      if (reload) begin
        r_bit_cnt <= 3'd0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_paralelo.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo
// Description : Serial-to-parallel front end. Hunts for the COM symbol at any
//               bit offset, confirms lock after BC_TARGET consecutive COMs on
//               the byte grid, then deals non-COM bytes round-robin onto four
//               lanes. A COM while active is idle and restarts at lane 0.
// Ports       : clk                     - rising-edge clock
//               reset                   - asynchronous active-low reset
//               data_in                 - serial input, MSB first
//               data_out0..data_out3    - lane bytes, held until overwritten
//               valid_out0..valid_out3  - one-cycle new-byte pulse per lane
//               active                  - link synchronized
// Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter logic [7:0] COM       = c_COM,
  parameter int         BC_TARGET = c_BC_TARGET
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [7:0] data_out2,
  output logic [7:0] data_out3,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       valid_out2,
  output logic       valid_out3,
  output logic       active
);

  localparam logic [2:0] c_BC_TGT = 3'(BC_TARGET);

  logic [1:0] r_state;
  logic [2:0] r_bc_cnt;
  logic [1:0] r_lane_ptr;
  logic [7:0] r_data [c_NUM_LANES];
  logic [3:0] r_valid;
  logic       r_active;

  logic [1:0] w_nxt_state;
  logic [2:0] w_nxt_bc_cnt;
  logic [1:0] w_nxt_lane_ptr;
  logic       w_fwd;
  logic       w_reload;
  logic [7:0] w_cand;
  logic [2:0] w_bit_cnt;
  logic       w_byte_done;

  // Any COM seen while hunting fixes the byte grid on this edge.
  assign w_reload = (r_state == c_ST_SEARCH) && (w_cand == COM);

  deserializador_byte u_deser (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .reload    (w_reload),
    .cand      (w_cand),
    .bit_cnt   (w_bit_cnt),
    .byte_done (w_byte_done)
  );

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_bc_cnt   = r_bc_cnt;
    w_nxt_lane_ptr = r_lane_ptr;
    w_fwd          = 1'b0;
    case (r_state)
      c_ST_SEARCH: begin
        if (w_cand == COM) begin
          w_nxt_bc_cnt = 3'd1;
          // A threshold of one COM locks straight away.
          if (c_BC_TGT == 3'd1) begin
            w_nxt_state    = c_ST_ACTIVE;
            w_nxt_lane_ptr = 2'd0;
          end else begin
            w_nxt_state = c_ST_SYNC;
          end
        end
      end
      c_ST_SYNC: begin
        if (w_byte_done) begin
          if (w_cand == COM) begin
            w_nxt_bc_cnt = r_bc_cnt + 3'd1;
            if (r_bc_cnt + 3'd1 == c_BC_TGT) begin
              w_nxt_state    = c_ST_ACTIVE;
              w_nxt_lane_ptr = 2'd0;
            end
          end else begin
            w_nxt_state  = c_ST_SEARCH;
            w_nxt_bc_cnt = 3'd0;
          end
        end
      end
      c_ST_ACTIVE: begin
        if (w_byte_done) begin
          if (w_cand == COM) begin
            w_nxt_lane_ptr = 2'd0;
          end else begin
            w_fwd          = 1'b1;
            w_nxt_lane_ptr = next_lane(r_lane_ptr);
          end
        end
      end
      default: begin
        w_nxt_state  = c_ST_SEARCH;
        w_nxt_bc_cnt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_ST_SEARCH;
      r_bc_cnt   <= 3'd0;
      r_lane_ptr <= 2'd0;
      r_valid    <= 4'b0000;
      r_active   <= 1'b0;
      for (int i = 0; i < c_NUM_LANES; i++) begin
        r_data[i] <= 8'h00;
      end
    end else begin
      r_state    <= w_nxt_state;
      r_bc_cnt   <= w_nxt_bc_cnt;
      r_lane_ptr <= w_nxt_lane_ptr;
      r_active   <= (w_nxt_state == c_ST_ACTIVE);
      r_valid    <= 4'b0000;
      if (w_fwd) begin
        r_data[r_lane_ptr]  <= w_cand;
        r_valid[r_lane_ptr] <= 1'b1;
      end
    end
  end

  assign data_out0  = r_data[0];
  assign data_out1  = r_data[1];
  assign data_out2  = r_data[2];
  assign data_out3  = r_data[3];
  assign valid_out0 = r_valid[0];
  assign valid_out1 = r_valid[1];
  assign valid_out2 = r_valid[2];
  assign valid_out3 = r_valid[3];
  assign active     = r_active;

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_paralelo
// Description : Self-checking bench for serial_paralelo. A bit-level
//               reference model tracks alignment by counting bits since the
//               last boundary and predicts lane contents, pulses and lock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo;
  import serial_paralelo_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       active;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  logic [7:0] m_win;
  int         m_mode;   // 0 hunting, 1 confirming, 2 locked
  int         m_cnt;
  int         m_pos;
  int         m_lane;
  logic [7:0] m_out [4];
  logic [3:0] m_v;
  logic       m_act;

  // Log of observed valid pulses
  int         p_lane [$];
  logic [7:0] p_val  [$];
  int         p_cyc  [$];

  serial_paralelo dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .data_out3  (data_out3),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .valid_out2 (valid_out2),
    .valid_out3 (valid_out3),
    .active     (active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_win  = 8'h00;
    m_mode = 0;
    m_cnt  = 0;
    m_pos  = 0;
    m_lane = 0;
    m_v    = 4'b0000;
    m_act  = 1'b0;
    for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
  endtask

  task automatic model_step(input logic b);
    m_v   = 4'b0000;
    m_win = {m_win[6:0], b};
    if (m_mode == 0) begin
      if (m_win == c_COM) begin
        m_mode = (c_BC_TARGET == 1) ? 2 : 1;
        m_cnt  = 1;
        m_pos  = 0;
        m_lane = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == 8) begin
        m_pos = 0;
        if (m_mode == 1) begin
          if (m_win == c_COM) begin
            m_cnt++;
            if (m_cnt == c_BC_TARGET) begin
              m_mode = 2;
              m_lane = 0;
            end
          end else begin
            m_mode = 0;
            m_cnt  = 0;
          end
        end else if (m_win == c_COM) begin
          m_lane = 0;
        end else begin
          m_out[m_lane] = m_win;
          m_v[m_lane]   = 1'b1;
          m_lane        = (m_lane + 1) % 4;
        end
      end
    end
    m_act = (m_mode == 2);
  endtask

  task automatic compare_outputs();
    logic [3:0] v;
    logic [7:0] d [4];
    v = {valid_out3, valid_out2, valid_out1, valid_out0};
    d[0] = data_out0; d[1] = data_out1; d[2] = data_out2; d[3] = data_out3;
    check("data_out0", data_out0, m_out[0]);
    check("data_out1", data_out1, m_out[1]);
    check("data_out2", data_out2, m_out[2]);
    check("data_out3", data_out3, m_out[3]);
    check("valid_out", v, m_v);
    check("valid_onehot", ($countones(v) <= 1), 1);
    check("active", active, m_act);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        p_lane.push_back(i);
        p_val.push_back(d[i]);
        p_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic clear_log();
    p_lane.delete();
    p_val.delete();
    p_cyc.delete();
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    model_step(b);
    #1;
    compare_outputs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_coms(input int n);
    for (int i = 0; i < n; i++) send_byte(c_COM);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_data0", data_out0, 0);
    check("rst_data1", data_out1, 0);
    check("rst_data2", data_out2, 0);
    check("rst_data3", data_out3, 0);
    check("rst_valid", {valid_out3, valid_out2, valid_out1, valid_out0}, 0);
    check("rst_active", active, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_log();
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    model_reset();
    #1;
    check("por_active", active, 0);
    check("por_valid", {valid_out3, valid_out2, valid_out1, valid_out0}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Lock from reset on four COMs, no lane traffic
    clear_log();
    send_coms(4);
    check("lock_active", active, 1);
    check("lock_no_pulse", p_lane.size(), 0);

    // Junk offset, lock, then four data bytes across the lanes
    async_reset();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_coms(4);
    check("junk_lock", active, 1);
    clear_log();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("lanes_d0", data_out0, 8'h11);
    check("lanes_d1", data_out1, 8'h22);
    check("lanes_d2", data_out2, 8'h33);
    check("lanes_d3", data_out3, 8'h44);
    check("lanes_npulse", p_lane.size(), 4);
    if (p_lane.size() == 4) begin
      for (int i = 0; i < 4; i++) check("lanes_order", p_lane[i], i);
      for (int i = 1; i < 4; i++) check("lanes_spacing", p_cyc[i] - p_cyc[i-1], 8);
    end

    // Non-COM while confirming drops back to hunting
    async_reset();
    send_coms(2);
    send_byte(8'h55);
    check("sync_drop_active", active, 0);
    send_coms(3);
    check("sync_3com_active", active, 0);
    send_coms(1);
    check("sync_relock", active, 1);

    // Idle COM resets the lane pointer
    clear_log();
    send_byte(8'hA1); send_byte(8'hA2); send_byte(c_COM); send_byte(8'hA3);
    check("idle_npulse", p_lane.size(), 3);
    if (p_lane.size() == 3) begin
      check("idle_l0", p_lane[0], 0); check("idle_v0", p_val[0], 8'hA1);
      check("idle_l1", p_lane[1], 1); check("idle_v1", p_val[1], 8'hA2);
      check("idle_l2", p_lane[2], 0); check("idle_v2", p_val[2], 8'hA3);
    end

    // Five bytes wrap back onto lane 0
    send_byte(c_COM);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    check("wrap_d0", data_out0, 8'h05);
    check("wrap_d1", data_out1, 8'h02);
    check("wrap_d2", data_out2, 8'h03);
    check("wrap_d3", data_out3, 8'h04);

    // Reset midway through a byte discards it and forces a fresh lock
    send_byte(8'hA1);
    for (int i = 7; i >= 4; i--) send_bit(1'(8'hA2 >> i));
    async_reset();
    check("mid_active", active, 0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_coms(3);
    check("mid_3com_active", active, 0);
    send_coms(1);
    check("mid_relock", active, 1);

    // Randomized traffic checked cycle by cycle against the model
    for (int it = 0; it < 25; it++) begin
      async_reset();
      for (int j = 0, n = $urandom_range(0, 15); j < n; j++) send_bit(1'($urandom));
      send_coms($urandom_range(1, 5));
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
      send_coms(4);
      for (int j = 0; j < 12; j++) begin
        if ($urandom_range(0, 4) == 0) send_byte(c_COM);
        else send_byte(8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
